// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: decodes the opcode once in DECODE
// and steps one instruction at a time through fetch/decode/execute/memory/writeback.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       extop,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] dbg_state
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
        S_BEQ    = 4'd8,  S_IEX    = 4'd9,  S_IWB    = 4'd10, S_JMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] CLS_R   = 3'd0;
    localparam logic [2:0] CLS_LW  = 3'd1;
    localparam logic [2:0] CLS_SW  = 3'd2;
    localparam logic [2:0] CLS_BEQ = 3'd3;
    localparam logic [2:0] CLS_IMM = 3'd4;
    localparam logic [2:0] CLS_J   = 3'd5;

    state_t     state, state_next;
    logic [2:0] cls, dec_cls;
    logic       lflag, dec_lflag, dec_legal;
    logic       pcwrite, branch;

    always_comb begin
        dec_cls   = CLS_R;
        dec_lflag = 1'b0;
        dec_legal = 1'b1;
        case (op)
            OP_R:    dec_cls = CLS_R;
            OP_LW:   dec_cls = CLS_LW;
            OP_SW:   dec_cls = CLS_SW;
            OP_BEQ:  dec_cls = CLS_BEQ;
            OP_ADDI: dec_cls = CLS_IMM;
            OP_ANDI: begin dec_cls = CLS_IMM; dec_lflag = 1'b1; end
            OP_ORI:  begin dec_cls = CLS_IMM; dec_lflag = 1'b1; end
            OP_J:    dec_cls = CLS_J;
            default: dec_legal = 1'b0;
        endcase
    end

    // Class and logic flag are latched only while leaving DECODE so op may wander afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            cls   <= 3'd0;
            lflag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                cls   <= dec_cls;
                lflag <= dec_lflag;
            end
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (!dec_legal)              state_next = S_FETCH;
                else if (dec_cls == CLS_LW || dec_cls == CLS_SW) state_next = S_MEMADR;
                else if (dec_cls == CLS_R)   state_next = S_REX;
                else if (dec_cls == CLS_BEQ) state_next = S_BEQ;
                else if (dec_cls == CLS_IMM) state_next = S_IEX;
                else                         state_next = S_JMP;
            end
            S_MEMADR: state_next = (cls == CLS_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_REX:    state_next = S_RWB;
            S_IEX:    state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        extop    = 1'b1;
        retire   = 1'b0;
        illegal  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (state)
            S_FETCH:  begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
            S_DECODE: begin alusrcb = 2'b11; illegal = ~dec_legal; end
            S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
            S_MEMRD:  iord = 1'b1;
            S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; retire = 1'b1; end
            S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; retire = 1'b1; end
            S_REX:    begin alusrca = 1'b1; aluop = 2'b10; end
            S_RWB:    begin regwrite = 1'b1; regdst = 1'b1; retire = 1'b1; end
            S_BEQ:    begin
                alusrca = 1'b1; aluop = 2'b01; branch = 1'b1; pcsrc = 2'b01; retire = 1'b1;
            end
            S_IEX:    begin
                alusrca = 1'b1; alusrcb = 2'b10;
                aluop   = lflag ? 2'b11 : 2'b00;
                extop   = ~lflag;
            end
            S_IWB:    begin regwrite = 1'b1; extop = ~lflag; retire = 1'b1; end
            S_JMP:    begin pcwrite = 1'b1; pcsrc = 2'b10; retire = 1'b1; end
            default:  ;
        endcase
        // Write enables are squashed the moment reset rises, before the state register settles.
        if (rst) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
        pcen = pcwrite | (branch & zero);
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions and random opcode streams checked
// against a per-instruction state-sequence model and the per-state control table.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst, zero;
    logic [5:0] op;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcen, extop, retire, illegal;
    logic [3:0] dbg_state;
    logic [16:0] ctl;

    int total = 0;
    int bad   = 0;

    localparam logic [16:0] RST_CTL = 17'b0000000_01_00_00_0_1_0_0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
        .extop(extop), .retire(retire), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign ctl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, aluop, pcsrc, pcen, extop, retire, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                         6'b001000, 6'b001100, 6'b001101, 6'b000010};
    endfunction

    function automatic bit is_logic(input logic [5:0] o);
        return (o == 6'b001100) || (o == 6'b001101);
    endfunction

    // State walk of one whole instruction, FETCH first.
    function automatic int seq_len(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000, 6'b001100, 6'b001101: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int seq_state(input logic [5:0] o, input int i);
        int s[5];
        case (o)
            6'b100011: s = '{0, 1, 2, 3, 4};
            6'b101011: s = '{0, 1, 2, 5, 0};
            6'b000000: s = '{0, 1, 6, 7, 0};
            6'b000100: s = '{0, 1, 8, 0, 0};
            6'b001000, 6'b001100, 6'b001101: s = '{0, 1, 9, 10, 0};
            6'b000010: s = '{0, 1, 11, 0, 0};
            default:   s = '{0, 1, 0, 0, 0};
        endcase
        return s[i];
    endfunction

    function automatic logic [16:0] exp_ctl(input int st, input bit lg, input bit badop, input bit z);
        logic e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_pcen, e_ext, e_ret, e_ill;
        logic [1:0] e_b, e_op, e_pcs;
        {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_pcen, e_ret, e_ill} = '0;
        e_b = 2'b00; e_op = 2'b00; e_pcs = 2'b00; e_ext = 1'b1;
        case (st)
            0:  begin e_irw = 1; e_pcen = 1; e_b = 2'b01; end
            1:  begin e_b = 2'b11; e_ill = badop; end
            2:  begin e_a = 1; e_b = 2'b10; end
            3:  e_iord = 1;
            4:  begin e_rw = 1; e_m2r = 1; e_ret = 1; end
            5:  begin e_iord = 1; e_mw = 1; e_ret = 1; end
            6:  begin e_a = 1; e_op = 2'b10; end
            7:  begin e_rw = 1; e_rd = 1; e_ret = 1; end
            8:  begin e_a = 1; e_op = 2'b01; e_pcs = 2'b01; e_pcen = z; e_ret = 1; end
            9:  begin e_a = 1; e_b = 2'b10; e_op = lg ? 2'b11 : 2'b00; e_ext = ~lg; end
            10: begin e_rw = 1; e_ext = ~lg; e_ret = 1; end
            11: begin e_pcen = 1; e_pcs = 2'b10; e_ret = 1; end
            default: ;
        endcase
        return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_b, e_op, e_pcs,
                e_pcen, e_ext, e_ret, e_ill};
    endfunction

    // Entered shortly after a rising edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input string name, input logic [5:0] o, input int zsel,
                             input bit fixed_after, input logic [5:0] after_op,
                             input int abort_at);
        int n;
        n = seq_len(o);
        for (int i = 0; i < n; i++) begin
            int st;
            bit zv;
            st = seq_state(o, i);
            if (i == 1)                     op = o;
            else if (i >= 2 && fixed_after) op = after_op;
            else                            op = 6'($urandom_range(0, 63));
            zv = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            zero = zv;
            #1;
            check($sformatf("%s_state%0d", name, i), 32'(dbg_state), 32'(st));
            check($sformatf("%s_ctl%0d", name, i), 32'(ctl),
                  32'(exp_ctl(st, is_logic(o), !is_legal(o), zv)));
            if (i == abort_at) begin
                #1 rst = 1'b1;
                #1;
                check($sformatf("%s_abort_state", name), 32'(dbg_state), 32'd0);
                check($sformatf("%s_abort_ctl", name), 32'(ctl), 32'(RST_CTL));
                @(posedge clk);
                #1 rst = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b001000, 6'b001100, 6'b001101, 6'b000010};
        rst  = 1'b1;
        op   = 6'b100011;
        zero = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_state", 32'(dbg_state), 32'd0);
            check("reset_ctl", 32'(ctl), 32'(RST_CTL));
        end
        rst = 1'b0;

        run_instr("lw",       6'b100011, -1, 1'b0, 6'h00, -1);
        run_instr("beq_z1",   6'b000100,  1, 1'b0, 6'h00, -1);
        run_instr("beq_z0",   6'b000100,  0, 1'b0, 6'h00, -1);
        run_instr("ori",      6'b001101, -1, 1'b0, 6'h00, -1);
        run_instr("addi",     6'b001000, -1, 1'b0, 6'h00, -1);
        run_instr("andi",     6'b001100, -1, 1'b0, 6'h00, -1);
        run_instr("illegal",  6'b111111, -1, 1'b0, 6'h00, -1);
        run_instr("sw_to_r",  6'b101011, -1, 1'b1, 6'b000000, -1);
        run_instr("j",        6'b000010, -1, 1'b0, 6'h00, -1);
        run_instr("r_abort",  6'b000000, -1, 1'b0, 6'h00, 3);
        run_instr("r_after",  6'b000000, -1, 1'b0, 6'h00, -1);

        for (int k = 0; k < 60; k++) begin
            int sel;
            logic [5:0] o;
            sel = $urandom_range(0, 9);
            o = (sel < 8) ? ops[sel] : 6'($urandom_range(0, 63));
            run_instr($sformatf("rand%0d_op%02h", k, o), o, -1, 1'b0, 6'h00, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the multicycle MIPS datapath (PC, instruction register, register file, ALU, memory port, immediate extender). It decodes the opcode once per instruction, steps through fetch/decode/execute/memory/writeback states, and drives every mux select and write enable, including the extender mode: sign-extend for arithmetic, load/store and branch offsets, zero-extend for logical immediates. One instruction is in flight at a time.

## Interface
- No parameters; state encoding and opcodes are fixed below.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  opcode from instruction register (IR[31:26])
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load enable
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2
- aluop  out  2  00 add, 01 sub, 10 use funct, 11 logical (ALU decoder uses op[0]: 0 = and, 1 = or)
- pcsrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC write enable = pcwrite | (branch & zero)
- extop  out  1  extender mode: 1 = sign, 0 = zero
- retire  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  one-cycle pulse in DECODE when op is unsupported

## Operation
- State register, 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQ=8, IEX=9, IWB=10, JMP=11. Codes 12–15 go to FETCH on the next edge.
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, andi 001100, ori 001101, j 000010.
- Instruction class register (3 bits) and a 1-bit logic flag (andi/ori) are captured from op on the DECODE→next edge only. Later states use these registers, not op.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw, sw), REX (R), BEQ, IEX (addi, andi, ori), JMP, or FETCH (illegal).
  - MEMADR→MEMRD (lw) or MEMWR (sw). MEMRD→MEMWB. REX→RWB. IEX→IWB.
  - MEMWB, MEMWR, RWB, BEQ, IWB, JMP→FETCH.
- Asserted outputs per state (all others 0, except extop, which is 1 unless stated):
  - FETCH: irwrite, pcwrite, alusrcb=01.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca, alusrcb=10.
  - MEMRD: iord.
  - MEMWB: regwrite, memtoreg.
  - MEMWR: iord, memwrite.
  - REX: alusrca, aluop=10.
  - RWB: regwrite, regdst.
  - BEQ: alusrca, aluop=01, branch, pcsrc=01.
  - IEX: alusrca, alusrcb=10; aluop=11 and extop=0 if logic flag, else aluop=00.
  - IWB: regwrite; extop=0 if logic flag.
  - JMP: pcwrite, pcsrc=10.
- retire is high in MEMWB, MEMWR, RWB, BEQ, IWB and JMP. illegal is high in DECODE when op is unsupported.

## Timing
- Reset: state=FETCH, class=0, logic flag=0. While rst=1, irwrite, pcen, memwrite, regwrite, retire and illegal are forced to 0. Other outputs show FETCH values: alusrcb=01, extop=1, all others 0.
- Reset deasserted mid-instruction: the FSM restarts at FETCH. No partial writeback occurs after reset is asserted.
- All outputs are combinational from state and the class/flag registers, except illegal, which also depends on op in DECODE. No output depends on zero except pcen.
- Cycle counts from FETCH entry to the next FETCH: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3, illegal 2.
- op may change in any state other than DECODE without affecting the FSM.

## Test plan
- Reset held 3 cycles, then released with op=100011 → state 0,1,2,3,4,0; regwrite=memtoreg=1 only in cycle 5; retire pulses once.
- op=000100, zero=1 → pcen=1 in FETCH and BEQ, pcsrc=01 in BEQ. Repeat with zero=0 → pcen=0 in BEQ.
- op=001101 → extop=0 and aluop=11 in IEX, extop=0 in IWB. op=001000 → extop=1 and aluop=00 in IEX.
- op=111111 → illegal pulse in DECODE, back to FETCH next cycle, no regwrite/memwrite.
- op changed from 101011 to 000000 while in MEMADR → FSM still takes MEMWR (memwrite=1, iord=1).
- rst asserted asynchronously mid-RWB → regwrite drops immediately; state=FETCH after release.
